// File: rtl/fp_pack_pkg.sv
// Shared types and constants for the float32 narrowing packer.
// Round modes, IEEE field widths, per-lane flag struct and the stage-1 rounding decision.
package fp_pack_pkg;

  localparam int F32_EXP_W = 8;
  localparam int F32_MAN_W = 23;

  typedef enum logic [1:0] {
    RNE = 2'd0,
    RTZ = 2'd1,
    RUP = 2'd2,
    RDN = 2'd3
  } round_mode_e;

  typedef struct packed {
    logic nan;
    logic overflow;
    logic inexact;
  } fp_flags_t;

  // Everything stage 2 needs about a lane besides its kept upper bits.
  typedef struct packed {
    logic up;
    logic is_nan;
    logic is_inf;
    logic inexact_raw;
  } round_dec_t;

endpackage

// File: rtl/fp32_round_lane.sv
// One lane of the packer: classify/decide on the raw float32, and apply the decision
// to the kept upper bits one stage later. Both halves are purely combinational.
module fp32_round_lane
  import fp_pack_pkg::*;
#(
  parameter int MANT_W = 7,
  localparam int OUT_W = 9 + MANT_W
) (
  input  logic [31:0]      cls_data_i,
  input  round_mode_e      cls_mode_i,
  output round_dec_t       cls_dec_o,
  input  logic [OUT_W-1:0] app_word_i,
  input  round_dec_t       app_dec_i,
  output logic [OUT_W-1:0] app_res_o,
  output fp_flags_t        app_flags_o
);

  localparam int D = F32_MAN_W - MANT_W;
  // Bits below the guard; collapses to an empty mask when only one bit is dropped.
  localparam logic [F32_MAN_W-1:0] STICKY_MASK = (F32_MAN_W'(1) << (D - 1)) - F32_MAN_W'(1);
  localparam logic [OUT_W-1:0] QUIET_BIT = OUT_W'(1) << (MANT_W - 1);

  logic                 sign;
  logic [F32_EXP_W-1:0] exp_f;
  logic [F32_MAN_W-1:0] man_f;
  logic                 lsb;
  logic                 guard;
  logic                 sticky;

  assign sign   = cls_data_i[31];
  assign exp_f  = cls_data_i[30:23];
  assign man_f  = cls_data_i[22:0];
  assign lsb    = cls_data_i[D];
  assign guard  = cls_data_i[D-1];
  assign sticky = |(man_f & STICKY_MASK);

  always_comb begin
    cls_dec_o             = '0;
    cls_dec_o.is_nan      = (exp_f == '1) && (man_f != '0);
    cls_dec_o.is_inf      = (exp_f == '1) && (man_f == '0);
    cls_dec_o.inexact_raw = guard || sticky;
    unique case (cls_mode_i)
      RNE:     cls_dec_o.up = guard && (sticky || lsb);
      RTZ:     cls_dec_o.up = 1'b0;
      RUP:     cls_dec_o.up = (guard || sticky) && !sign;
      RDN:     cls_dec_o.up = (guard || sticky) && sign;
      default: cls_dec_o.up = 1'b0;
    endcase
    if (cls_dec_o.is_nan || cls_dec_o.is_inf) cls_dec_o.up = 1'b0;
  end

  // A mantissa carry ripples into the exponent on purpose: subnormal->normal, max->Inf.
  always_comb begin
    app_flags_o = '0;
    if (app_dec_i.is_nan) app_res_o = app_word_i | QUIET_BIT;
    else                  app_res_o = app_word_i + {{(OUT_W-1){1'b0}}, app_dec_i.up};
    app_flags_o.nan      = app_dec_i.is_nan;
    app_flags_o.overflow = !app_dec_i.is_nan && !app_dec_i.is_inf &&
                           (app_res_o[OUT_W-2:MANT_W] == '1);
    app_flags_o.inexact  = (app_dec_i.inexact_raw && !app_dec_i.is_nan && !app_dec_i.is_inf) ||
                           app_flags_o.overflow;
  end

endmodule

// File: rtl/fp32_narrow_pack.sv
// Streaming float32 -> (1,8,MANT_W) packer: two register stages, LANES lanes per beat,
// per-beat rounding mode, per-lane flags and sticky status.
module fp32_narrow_pack
  import fp_pack_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int MANT_W = 7,
  localparam int OUT_W = 9 + MANT_W
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  input  logic [32*LANES-1:0]    s_data_i,
  input  logic [1:0]             s_mode_i,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic [OUT_W*LANES-1:0] m_data_o,
  output logic [3*LANES-1:0]     m_flags_o,
  output logic [2:0]             sts_o,
  input  logic                   sts_clr_i
);

  localparam int D = F32_MAN_W - MANT_W;

  // A beat moves on an edge where valid && ready on that side. Both stages shift together
  // whenever the output slot is empty or being taken, so s_ready_o is that same condition.
  logic adv;
  logic out_hs;
  assign adv       = !m_valid_o || m_ready_i;
  assign s_ready_o = adv;
  assign out_hs    = m_valid_o && m_ready_i;

  logic                   s1_valid_q;
  logic [OUT_W-1:0]       s1_word_q [LANES];
  round_dec_t             s1_dec_q  [LANES];
  round_dec_t             dec_c     [LANES];
  logic [OUT_W-1:0]       res_c     [LANES];
  fp_flags_t              flags_c   [LANES];
  logic [OUT_W*LANES-1:0] data_c;
  logic [3*LANES-1:0]     flags_vec_c;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    fp32_round_lane #(.MANT_W(MANT_W)) u_lane (
      .cls_data_i  (s_data_i[32*k +: 32]),
      .cls_mode_i  (round_mode_e'(s_mode_i)),
      .cls_dec_o   (dec_c[k]),
      .app_word_i  (s1_word_q[k]),
      .app_dec_i   (s1_dec_q[k]),
      .app_res_o   (res_c[k]),
      .app_flags_o (flags_c[k])
    );
    assign data_c[OUT_W*k +: OUT_W] = res_c[k];
    assign flags_vec_c[3*k +: 3]    = flags_c[k];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        s1_word_q[k] <= '0;
        s1_dec_q[k]  <= '0;
      end
      m_valid_o <= 1'b0;
      m_data_o  <= '0;
      m_flags_o <= '0;
    end else if (adv) begin
      s1_valid_q <= s_valid_i;
      if (s_valid_i) begin
        for (int k = 0; k < LANES; k++) begin
          s1_word_q[k] <= s_data_i[32*k+D +: OUT_W];
          s1_dec_q[k]  <= dec_c[k];
        end
      end
      m_valid_o <= s1_valid_q;
      if (s1_valid_q) begin
        m_data_o  <= data_c;
        m_flags_o <= flags_vec_c;
      end
    end
  end

  logic [2:0] hs_flags;
  always_comb begin
    hs_flags = '0;
    for (int k = 0; k < LANES; k++) hs_flags = hs_flags | m_flags_o[3*k +: 3];
  end

  // A clear in the same cycle as a handshake keeps that handshake's flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        sts_o <= '0;
    else if (sts_clr_i) sts_o <= out_hs ? hs_flags : 3'b000;
    else if (out_hs)    sts_o <= sts_o | hs_flags;
  end

endmodule

// File: tb/tb_fp32_narrow_pack.sv
// Bench for fp32_narrow_pack: directed vectors, sticky/backpressure/reset scenarios and a
// randomized stream, scored against an arithmetic rounding model.
module tb_fp32_narrow_pack;

  localparam int LANES  = 4;
  localparam int MANT_W = 7;
  localparam int OUT_W  = 9 + MANT_W;
  localparam int DW     = OUT_W * LANES;
  localparam int FW     = 3 * LANES;
  localparam int W      = DW + FW;
  localparam int unsigned SCALE = 65536;  // 2**(23-MANT_W)
  localparam int unsigned HALF  = 32768;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              s_valid_i;
  logic              s_ready_o;
  logic [32*LANES-1:0] s_data_i;
  logic [1:0]        s_mode_i;
  logic              m_valid_o;
  logic              m_ready_i;
  logic [DW-1:0]     m_data_o;
  logic [FW-1:0]     m_flags_o;
  logic [2:0]        sts_o;
  logic              sts_clr_i;

  fp32_narrow_pack #(.LANES(LANES), .MANT_W(MANT_W)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .s_data_i  (s_data_i),
    .s_mode_i  (s_mode_i),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .m_data_o  (m_data_o),
    .m_flags_o (m_flags_o),
    .sts_o     (sts_o),
    .sts_clr_i (sts_clr_i)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- scoreboard state ----------------
  logic [W-1:0]  exp_q[$];
  int            meta_q[$];   // negedge index at acceptance, -1 when latency is not checked
  logic [19:0]   gold_q[$];   // {has, lane0 result, lane0 flags}
  logic [19:0]   cur_gold;
  logic [2:0]    exp_sts;
  logic          front_seen;
  logic          was_stall;
  logic [DW-1:0] held_data;
  logic [FW-1:0] held_flags;
  int            ncyc;
  int            n_checks;
  int            n_fail;
  int            rdy_mode;
  int            bp_cyc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [18:0] ref_lane(input logic [31:0] x, input logic [1:0] mode);
    int unsigned mag, q, rem;
    logic up, ovf, inx;
    logic [15:0] res;
    if (x[30:23] == 8'hFF && x[22:0] != 23'd0) return {x[31:16] | 16'h0040, 3'b100};
    if (x[30:23] == 8'hFF) return {x[31:16], 3'b000};
    mag = {1'b0, x[30:0]};
    q   = mag / SCALE;
    rem = mag % SCALE;
    case (mode)
      2'd0:    up = (rem > HALF) || (rem == HALF && (q % 2) == 1);
      2'd1:    up = 1'b0;
      2'd2:    up = (rem != 0) && !x[31];
      default: up = (rem != 0) && x[31];
    endcase
    q   = q + int'(up);
    ovf = (q / 128) == 255;
    inx = (rem != 0) || ovf;
    res = {x[31], q[14:0]};
    return {res, 1'b0, ovf, inx};
  endfunction

  function automatic logic [W-1:0] ref_beat(input logic [32*LANES-1:0] d, input logic [1:0] mode);
    logic [DW-1:0] od;
    logic [FW-1:0] of;
    logic [18:0]   r;
    for (int k = 0; k < LANES; k++) begin
      r = ref_lane(d[32*k +: 32], mode);
      od[OUT_W*k +: OUT_W] = r[18:3];
      of[3*k +: 3]         = r[2:0];
    end
    return {od, of};
  endfunction

  function automatic logic [2:0] or_flags(input logic [FW-1:0] f);
    logic [2:0] o = 3'b000;
    for (int k = 0; k < LANES; k++) o = o | f[3*k +: 3];
    return o;
  endfunction

  function automatic logic [31:0] rand_f32();
    logic [31:0] r;
    case ($urandom_range(0, 7))
      0:       r = {1'($urandom), 8'hFF, 23'($urandom)};
      1:       r = {1'($urandom), 8'hFF, 23'h0};
      2:       r = {1'($urandom), 31'h7F7F0000 | 31'($urandom_range(0, 65535))};
      3:       r = ($urandom & 32'hFFFF_0000) | 32'h0000_8000;
      4:       r = {1'($urandom), 8'h00, 23'($urandom)};
      5:       r = {1'($urandom), 31'h0};
      default: r = $urandom;
    endcase
    return r;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk_i) begin
    logic [W-1:0] e;
    logic [19:0]  g;
    int           m;
    logic         hs_done;
    ncyc++;
    hs_done = 1'b0;
    if (!rst_ni) begin
      chk("rst_valid", 64'(m_valid_o), 64'd0);
      chk("rst_data", 64'(m_data_o), 64'd0);
      chk("rst_flags", 64'(m_flags_o), 64'd0);
      chk("rst_sts", 64'(sts_o), 64'd0);
    end else begin
      chk("sts", 64'(sts_o), 64'(exp_sts));
      if (was_stall) begin
        chk("hold_valid", 64'(m_valid_o), 64'd1);
        chk("hold_data", 64'(m_data_o), 64'(held_data));
        chk("hold_flags", 64'(m_flags_o), 64'(held_flags));
      end
      was_stall = m_valid_o && !m_ready_i;
      if (was_stall) begin
        chk("ready_low", 64'(s_ready_o), 64'd0);
        held_data  = m_data_o;
        held_flags = m_flags_o;
      end
      if (m_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 64'(m_valid_o), 64'd0);
        end else begin
          if (!front_seen) begin
            front_seen = 1'b1;
            if (meta_q[0] >= 0) chk("latency", 64'(ncyc - meta_q[0]), 64'd2);
          end
          if (m_ready_i) begin
            e = exp_q.pop_front();
            m = meta_q.pop_front();
            g = gold_q.pop_front();
            front_seen = 1'b0;
            chk("data", 64'(m_data_o), 64'(e[W-1:FW]));
            chk("flags", 64'(m_flags_o), 64'(e[FW-1:0]));
            if (g[19]) begin
              chk("gold_res", 64'(m_data_o[15:0]), 64'(g[18:3]));
              chk("gold_flags", 64'(m_flags_o[2:0]), 64'(g[2:0]));
            end
            exp_sts = (sts_clr_i ? 3'b000 : exp_sts) | or_flags(e[FW-1:0]);
            hs_done = 1'b1;
          end
        end
      end
      if (!hs_done && sts_clr_i) exp_sts = 3'b000;
      if (s_valid_i && s_ready_o) begin
        meta_q.push_back(exp_q.size() == 0 ? ncyc : -1);
        exp_q.push_back(ref_beat(s_data_i, s_mode_i));
        gold_q.push_back(cur_gold);
      end
    end
  end

  // ---------------- downstream ready driver ----------------
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      bp_cyc++;
      case (rdy_mode)
        1:       m_ready_i = ($urandom_range(0, 3) != 0);
        2:       m_ready_i = !(bp_cyc >= 3 && bp_cyc <= 7);
        default: m_ready_i = 1'b1;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic send_beat(input logic [32*LANES-1:0] d, input logic [1:0] mode,
                           input logic [19:0] gold);
    logic acc = 1'b0;
    int   n   = 0;
    s_valid_i = 1'b1;
    s_data_i  = d;
    s_mode_i  = mode;
    cur_gold  = gold;
    while (!acc && n < 200) begin
      @(negedge clk_i);
      acc = s_ready_o;
      step();
      n++;
    end
    if (!acc) chk("accept_timeout", 64'(acc), 64'd1);
    s_valid_i = 1'b0;
    cur_gold  = '0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [32*LANES-1:0] rand_beat();
    logic [32*LANES-1:0] d;
    for (int k = 0; k < LANES; k++) d[32*k +: 32] = rand_f32();
    return d;
  endfunction

  // ---------------- directed table ----------------
  localparam int ND = 15;
  logic [31:0] dir_in  [ND] = '{32'h3F808000, 32'h3F818000, 32'h3F808001, 32'h3F800000,
                                32'h3F800001, 32'hBF800001, 32'h3F800001, 32'hBF800001,
                                32'h3F800001, 32'hBF800001, 32'h7F7FFFFF, 32'h7F7FFFFF,
                                32'hFF800001, 32'h7F800000, 32'h00000000};
  logic [1:0]  dir_md  [ND] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd3, 2'd3,
                                2'd1, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
  logic [15:0] dir_res [ND] = '{16'h3F80, 16'h3F82, 16'h3F81, 16'h3F80, 16'h3F81, 16'hBF80,
                                16'h3F80, 16'hBF81, 16'h3F80, 16'hBF80, 16'h7F80, 16'h7F7F,
                                16'hFFC0, 16'h7F80, 16'h0000};
  logic [2:0]  dir_flg [ND] = '{3'b001, 3'b001, 3'b001, 3'b000, 3'b001, 3'b001, 3'b001,
                                3'b001, 3'b001, 3'b001, 3'b011, 3'b001, 3'b100, 3'b000,
                                3'b000};

  // ---------------- main sequence ----------------
  initial begin
    logic [32*LANES-1:0] d;
    int n;
    n_checks = 0; n_fail = 0; ncyc = 0; bp_cyc = 0; rdy_mode = 0;
    exp_sts = 3'b000; front_seen = 1'b0; was_stall = 1'b0;
    held_data = '0; held_flags = '0; cur_gold = '0;
    rst_ni = 1'b0; s_valid_i = 1'b0; s_data_i = '0; s_mode_i = 2'd0;
    m_ready_i = 1'b1; sts_clr_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    step();

    // Directed vectors on lane 0, random traffic on the others.
    for (int i = 0; i < ND; i++) begin
      d = rand_beat();
      d[31:0] = dir_in[i];
      send_beat(d, dir_md[i], {1'b1, dir_res[i], dir_flg[i]});
    end
    drain();

    // Sticky status.
    sts_clr_i = 1'b1; step(); sts_clr_i = 1'b0;
    chk("sts_clear_idle", 64'(sts_o), 64'd0);
    send_beat({LANES{32'h3F800001}}, 2'd1, '0);
    drain();
    chk("sts_inexact", 64'(sts_o), 64'b001);
    send_beat({LANES{32'h7F7FFFFF}}, 2'd0, '0);
    n = 0;
    while (!m_valid_o && n < 20) begin step(); n++; end
    chk("sts_ovf_valid", 64'(m_valid_o), 64'd1);
    sts_clr_i = 1'b1; step(); sts_clr_i = 1'b0;
    chk("sts_clr_with_ovf", 64'(sts_o), 64'b011);
    sts_clr_i = 1'b1; step(); sts_clr_i = 1'b0;
    chk("sts_lone_clear", 64'(sts_o), 64'd0);

    // Backpressure: six back-to-back beats, downstream stalled for cycles 3..7.
    bp_cyc = 0;
    rdy_mode = 2;
    for (int i = 0; i < 6; i++) send_beat(rand_beat(), 2'($urandom_range(0, 3)), '0);
    drain();
    rdy_mode = 0;

    // Reset with two beats in flight.
    send_beat({LANES{32'h3F800001}}, 2'd0, '0);
    send_beat({LANES{32'h7F7FFFFF}}, 2'd0, '0);
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(m_valid_o), 64'd0);
    chk("rst_mid_sts", 64'(sts_o), 64'd0);
    exp_q.delete(); meta_q.delete(); gold_q.delete();
    exp_sts = 3'b000; front_seen = 1'b0; was_stall = 1'b0;
    repeat (2) step();
    rst_ni = 1'b1;
    repeat (4) step();
    send_beat({LANES{32'h3F818000}}, 2'd0, {1'b1, 16'h3F82, 3'b001});
    drain();

    // Randomized stream with random gaps, modes and downstream stalls.
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      send_beat(rand_beat(), 2'($urandom_range(0, 3)), '0);
      repeat ($urandom_range(0, 2)) step();
      if ($urandom_range(0, 15) == 0) begin
        sts_clr_i = 1'b1; step(); sts_clr_i = 1'b0;
      end
    end
    rdy_mode = 0;
    drain();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
